// File: rtl/mem_req_arb_pkg.sv
// Shared memory-request types for the request arbiter and its FIFOs.
// Request word layout is {we, tid, line address, parity}.
package libmemif;

  localparam int ICACHEINDEXLSB_MEM = 4;
  localparam int TIDW  = 4;
  localparam int ADDRW = 32 - ICACHEINDEXLSB_MEM;

  localparam int MEMARB_RR    = 0;
  localparam int MEMARB_FIXED = 1;

  typedef struct packed {
    logic             we;
    logic [TIDW-1:0]  tid;
    logic [ADDRW-1:0] addr;
    logic             parity;
  } mem_req_word_type;

  localparam int REQW = $bits(mem_req_word_type);

  // Requestor-ID width; never narrower than one bit.
  function automatic int log2x(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic req_par(input mem_req_word_type w);
    return ^{w.we, w.tid, w.addr};
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Per-port request FIFO in distributed RAM; pointers carry an extra
// wrap bit so full and empty are told apart without a counter.
module mem_req_fifo
  import libmemif::*;
#(
  parameter int FIFODEPTH = 16
) (
  input  logic            gclk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [REQW-1:0] wr_data,
  input  logic            rd_en,
  output logic [REQW-1:0] rd_data,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(FIFODEPTH);

  logic [REQW-1:0] mem_q [FIFODEPTH];
  logic [AW:0]     wptr_q, wptr_d;
  logic [AW:0]     rptr_q, rptr_d;
  logic            do_wr, do_rd;

  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  assign rd_data = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + 1'b1;
    if (do_rd) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge gclk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mem_req_arb.sv
// Memory request arbiter: per-port FIFOs with parity screening, a
// credit-gated round-robin/fixed arbiter and one issue per cycle.
module mem_req_arb
  import libmemif::*;
#(
  parameter int NPORT     = 2,
  parameter int FIFODEPTH = 16,
  parameter int NCREDIT   = 4,
  parameter int ARBMODE   = MEMARB_RR,
  parameter int PARITYEN  = 1
) (
  input  logic                    gclk,
  input  logic                    rst,
  input  logic [NPORT-1:0]        req_valid,
  input  logic [NPORT*REQW-1:0]   req,
  output logic [NPORT-1:0]        req_ready,
  output logic                    mc_valid,
  output logic [REQW-1:0]         mc_req,
  output logic [log2x(NPORT)-1:0] mc_rid,
  input  logic                    mc_credit_ret,
  output logic                    perr,
  output logic [log2x(NPORT)-1:0] perr_rid,
  output logic                    cred_err,
  output logic [3:0]              ccnt
);

  localparam int         RIDW = log2x(NPORT);
  localparam logic [3:0] CMAX = 4'(NCREDIT);

  logic [NPORT-1:0] full, empty;
  logic [NPORT-1:0] par_bad, bad_acc;
  logic [NPORT-1:0] wr_en, rd_en;
  logic [REQW-1:0]  head [NPORT];

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    mem_req_word_type w;
    assign w = mem_req_word_type'(req[p*REQW +: REQW]);
    assign par_bad[p]   = (PARITYEN != 0) && (req_par(w) != w.parity);
    assign req_ready[p] = ~full[p];
    assign bad_acc[p]   = req_valid[p] & ~full[p] & par_bad[p];
    assign wr_en[p]     = req_valid[p] & ~full[p] & ~par_bad[p];

    mem_req_fifo #(
      .FIFODEPTH(FIFODEPTH)
    ) u_fifo (
      .gclk   (gclk),
      .rst    (rst),
      .wr_en  (wr_en[p]),
      .wr_data(req[p*REQW +: REQW]),
      .rd_en  (rd_en[p]),
      .rd_data(head[p]),
      .full   (full[p]),
      .empty  (empty[p])
    );
  end

  logic [RIDW-1:0]  rr_q, rr_d;
  logic [3:0]       ccnt_q, ccnt_d;
  logic             cred_err_q, cred_err_d;
  logic             mc_valid_q, mc_valid_d;
  logic [REQW-1:0]  mc_req_q, mc_req_d;
  logic [RIDW-1:0]  mc_rid_q, mc_rid_d;
  logic             perr_q, perr_d;
  logic [RIDW-1:0]  perr_rid_q, perr_rid_d;

  logic             gnt_any;
  logic [RIDW-1:0]  gnt_id;
  logic             issue;
  mem_req_word_type iss_word;

  // Scan from highest offset down so the nearest eligible port wins.
  always_comb begin : arb
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    if (ARBMODE == MEMARB_FIXED) begin
      for (int i = NPORT - 1; i >= 0; i--) begin
        if (!empty[i]) begin
          gnt_any = 1'b1;
          gnt_id  = RIDW'(i);
        end
      end
    end else begin
      for (int k = NPORT - 1; k >= 0; k--) begin
        idx = (int'(rr_q) + k) % NPORT;
        if (!empty[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = RIDW'(idx);
        end
      end
    end
  end

  assign issue = gnt_any && (ccnt_q != 4'd0);

  always_comb begin
    rd_en = '0;
    if (issue) rd_en[gnt_id] = 1'b1;
  end

  always_comb begin
    iss_word        = mem_req_word_type'(head[gnt_id]);
    iss_word.parity = req_par(iss_word);
  end

  always_comb begin
    rr_d = rr_q;
    if (issue) begin
      if (int'(gnt_id) == NPORT - 1) rr_d = '0;
      else rr_d = gnt_id + 1'b1;
    end
  end

  always_comb begin
    mc_valid_d = issue;
    mc_req_d   = mc_req_q;
    mc_rid_d   = mc_rid_q;
    if (issue) begin
      mc_req_d = iss_word;
      mc_rid_d = gnt_id;
    end
  end

  // A return at full credit is an overflow: hold the count, flag it.
  always_comb begin
    ccnt_d     = ccnt_q;
    cred_err_d = cred_err_q;
    unique case (1'b1)
      issue & ~mc_credit_ret: ccnt_d = ccnt_q - 4'd1;
      ~issue & mc_credit_ret: begin
        if (ccnt_q == CMAX) cred_err_d = 1'b1;
        else ccnt_d = ccnt_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    perr_d     = |bad_acc;
    perr_rid_d = perr_rid_q;
    for (int p = NPORT - 1; p >= 0; p--) begin
      if (bad_acc[p]) perr_rid_d = RIDW'(p);
    end
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      rr_q       <= '0;
      ccnt_q     <= CMAX;
      cred_err_q <= 1'b0;
      mc_valid_q <= 1'b0;
      mc_req_q   <= '0;
      mc_rid_q   <= '0;
      perr_q     <= 1'b0;
      perr_rid_q <= '0;
    end else begin
      rr_q       <= rr_d;
      ccnt_q     <= ccnt_d;
      cred_err_q <= cred_err_d;
      mc_valid_q <= mc_valid_d;
      mc_req_q   <= mc_req_d;
      mc_rid_q   <= mc_rid_d;
      perr_q     <= perr_d;
      perr_rid_q <= perr_rid_d;
    end
  end

  assign mc_valid = mc_valid_q;
  assign mc_req   = mc_req_q;
  assign mc_rid   = mc_rid_q;
  assign perr     = perr_q;
  assign perr_rid = perr_rid_q;
  assign cred_err = cred_err_q;
  assign ccnt     = ccnt_q;

endmodule

// File: tb/tb_mem_req_arb.sv
// Scoreboard bench for mem_req_arb: stimulus pushes expected issues,
// a negedge monitor pops and compares every mc_valid beat.
module tb_mem_req_arb;

  localparam int NP = 2;
  localparam int W  = 34;

  logic          gclk = 1'b0;
  logic          rst;
  logic [NP-1:0] req_valid;
  logic [NP*W-1:0] req;
  logic [NP-1:0] req_ready;
  logic          mc_valid;
  logic [W-1:0]  mc_req;
  logic [0:0]    mc_rid;
  logic          mc_credit_ret;
  logic          perr;
  logic [0:0]    perr_rid;
  logic          cred_err;
  logic [3:0]    ccnt;

  logic ret_stim = 1'b0;
  logic ret_auto = 1'b0;
  logic auto_ret = 1'b0;
  assign mc_credit_ret = ret_stim | ret_auto;

  int n_run  = 0;
  int n_fail = 0;
  int vcnt   = 0;

  typedef struct packed {
    logic         rid;
    logic [W-1:0] word;
  } exp_t;
  exp_t sb[$];

  always #5 gclk = ~gclk;

  mem_req_arb #(
    .NPORT    (2),
    .FIFODEPTH(4),
    .NCREDIT  (4),
    .ARBMODE  (0),
    .PARITYEN (1)
  ) dut (
    .gclk         (gclk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req          (req),
    .req_ready    (req_ready),
    .mc_valid     (mc_valid),
    .mc_req       (mc_req),
    .mc_rid       (mc_rid),
    .mc_credit_ret(mc_credit_ret),
    .perr         (perr),
    .perr_rid     (perr_rid),
    .cred_err     (cred_err),
    .ccnt         (ccnt)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic we,
                                      input logic [3:0] tid,
                                      input logic [27:0] addr);
    return {we, tid, addr, ^{we, tid, addr}};
  endfunction

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [W-1:0] w0,
                       input logic [W-1:0] w1);
    req_valid = v;
    req       = {w1, w0};
  endtask

  task automatic push(input logic rid, input logic [W-1:0] w);
    exp_t e;
    e.rid  = rid;
    e.word = w;
    sb.push_back(e);
  endtask

  always @(negedge gclk) begin : mon
    exp_t e;
    ret_auto = 1'b0;
    if (mc_valid === 1'b1) begin
      vcnt++;
      ret_auto = auto_ret;
      if (sb.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_issue: actual rid=%0d req=%h, required none",
                 mc_rid, mc_req);
      end else begin
        e = sb.pop_front();
        chk("mc_rid", 64'(mc_rid), 64'(e.rid));
        chk("mc_req", 64'(mc_req), 64'(e.word));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a [3];
    logic [W-1:0] b [3];
    logic [W-1:0] c [6];
    logic [W-1:0] d [5];
    logic [W-1:0] bad0, bad1, good0;
    logic [7:0]   vpat;
    logic         rdy;
    int           base;
    int           acc;

    for (int i = 0; i < 3; i++) begin
      a[i] = mk(1'b0, 4'(i), 28'h100 + 28'(i));
      b[i] = mk(1'b1, 4'(8 + i), 28'h200 + 28'(i));
    end
    for (int i = 0; i < 6; i++) c[i] = mk(1'b0, 4'(i), 28'h300 + 28'(i));
    for (int i = 0; i < 5; i++) d[i] = mk(1'b1, 4'(i), 28'h400 + 28'(i));

    rst = 1'b1;
    drive(2'b00, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_mc_valid", 64'(mc_valid), 64'd0);
    chk("rst_ccnt", 64'(ccnt), 64'd4);
    chk("rst_req_ready", 64'(req_ready), 64'h3);
    chk("rst_perr", 64'(perr), 64'd0);
    chk("rst_cred_err", 64'(cred_err), 64'd0);

    // Round robin over two loaded ports, credits recycled by the model.
    auto_ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, a[i]);
      push(1'b1, b[i]);
    end
    vpat = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) drive(2'b11, a[i], b[i]);
      else drive(2'b00, '0, '0);
      tick();
      vpat[i] = mc_valid;
    end
    chk("rr_valid_pattern", 64'(vpat), 64'h7e);
    chk("rr_ccnt_end", 64'(ccnt), 64'd4);
    chk("rr_cred_err", 64'(cred_err), 64'd0);
    auto_ret = 1'b0;

    // Credit exhaustion: 6 requests, only 4 credits.
    base = vcnt;
    for (int i = 0; i < 4; i++) push(1'b0, c[i]);
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, c[i], '0);
      tick();
    end
    drive(2'b00, '0, '0);
    repeat (6) tick();
    chk("cred_issue_count", 64'(vcnt - base), 64'd4);
    chk("cred_ccnt_zero", 64'(ccnt), 64'd0);
    push(1'b0, c[4]);
    ret_stim = 1'b1;
    tick();
    ret_stim = 1'b0;
    chk("ret_no_issue_yet", 64'(mc_valid), 64'd0);
    chk("ret_ccnt_one", 64'(ccnt), 64'd1);
    tick();
    chk("ret_issue_next", 64'(mc_valid), 64'd1);
    chk("ret_ccnt_back0", 64'(ccnt), 64'd0);
    repeat (3) tick();
    chk("ret_issue_count", 64'(vcnt - base), 64'd5);

    // FIFO fill on port 1 while starved of credit.
    base = vcnt;
    acc  = 0;
    for (int i = 0; i < 8; i++) begin
      drive(2'b10, '0, d[acc]);
      rdy = req_ready[1];
      tick();
      if (rdy) acc++;
    end
    chk("full_accepts", 64'(acc), 64'd4);
    chk("full_req_ready", 64'(req_ready), 64'h1);
    chk("full_no_issue", 64'(vcnt - base), 64'd0);
    drive(2'b00, '0, '0);

    // Reset with full FIFOs and zero credit.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_mc_valid", 64'(mc_valid), 64'd0);
    chk("rst2_ccnt", 64'(ccnt), 64'd4);
    chk("rst2_req_ready", 64'(req_ready), 64'h3);

    // Reset mid-operation: 3 queued, ccnt=1.
    push(1'b0, a[0]);
    push(1'b1, b[0]);
    push(1'b0, a[1]);
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, a[i], b[i]);
      tick();
    end
    drive(2'b00, '0, '0);
    tick();
    chk("mid_ccnt_one", 64'(ccnt), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_mc_valid", 64'(mc_valid), 64'd0);
    chk("mid_rst_ccnt", 64'(ccnt), 64'd4);
    chk("mid_rst_req_ready", 64'(req_ready), 64'h3);
    base = vcnt;
    repeat (6) tick();
    chk("mid_rst_discard", 64'(vcnt - base), 64'd0);

    // Parity screening.
    bad0  = mk(1'b0, 4'd3, 28'h500) ^ 34'd1;
    bad1  = mk(1'b1, 4'd5, 28'h600) ^ 34'd1;
    good0 = mk(1'b0, 4'd7, 28'h700);
    drive(2'b01, bad0, '0);
    tick();
    chk("perr_p0", 64'(perr), 64'd1);
    chk("perr_rid_p0", 64'(perr_rid), 64'd0);
    chk("perr_ready", 64'(req_ready), 64'h3);
    drive(2'b00, '0, '0);
    tick();
    chk("perr_pulse_end", 64'(perr), 64'd0);
    chk("perr_no_issue", 64'(mc_valid), 64'd0);
    drive(2'b11, bad0, bad1);
    tick();
    chk("perr_both", 64'(perr), 64'd1);
    chk("perr_rid_lowest", 64'(perr_rid), 64'd0);
    push(1'b0, good0);
    drive(2'b11, good0, bad1);
    tick();
    chk("perr_p1", 64'(perr), 64'd1);
    chk("perr_rid_p1", 64'(perr_rid), 64'd1);
    drive(2'b00, '0, '0);
    repeat (4) tick();
    chk("perr_ccnt", 64'(ccnt), 64'd3);
    chk("perr_sb_drained", 64'(sb.size()), 64'd0);

    // Credit overflow and stickiness.
    ret_stim = 1'b1;
    tick();
    chk("ovf_ccnt_fill", 64'(ccnt), 64'd4);
    chk("ovf_no_err_yet", 64'(cred_err), 64'd0);
    tick();
    ret_stim = 1'b0;
    chk("ovf_ccnt_hold", 64'(ccnt), 64'd4);
    chk("ovf_cred_err", 64'(cred_err), 64'd1);
    repeat (3) tick();
    chk("ovf_sticky", 64'(cred_err), 64'd1);
    chk("ovf_ccnt_still", 64'(ccnt), 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_rst_clear", 64'(cred_err), 64'd0);
    ret_stim = 1'b1;
    tick();
    ret_stim = 1'b0;
    chk("ovf_after_rst", 64'(cred_err), 64'd1);
    chk("ovf_after_rst_ccnt", 64'(ccnt), 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arb.md
MEM_REQ_ARB -- requirements
Module: mem_req_arb

Interface
REQ-001 SHALL take parameter NPORT, default 2, meaning the number of requestor channels (2..8; port 0 = I-side, port 1 = D-side).
REQ-002 SHALL take parameter FIFODEPTH, default 16, meaning entries per port FIFO (a power of 2, 4..64).
REQ-003 SHALL take parameter NCREDIT, default 4, meaning the maximum outstanding requests at the memory controller (1..15).
REQ-004 SHALL take parameter ARBMODE, default 0, meaning 0 = round-robin and 1 = fixed priority with port 0 highest.
REQ-005 SHALL take parameter PARITYEN, default 1, meaning 1 = check request parity on enqueue.
REQ-006 SHALL have port gclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port req_valid, input, NPORT bits: per-port request strobe.
REQ-009 SHALL have port req, input, NPORT x request-word bits: per-port request word {we, tid, addr[31:ICACHEINDEXLSB_MEM], parity}.
REQ-010 SHALL have port req_ready, output, NPORT bits: per-port not-full; a request is accepted when req_valid & req_ready.
REQ-011 SHALL have port mc_valid, output, 1 bit: issued-request strobe to the memory controller.
REQ-012 SHALL have port mc_req, output, request-word width: the issued request word, parity regenerated.
REQ-013 SHALL have port mc_rid, output, log2x(NPORT) bits: the requestor ID of the issued request.
REQ-014 SHALL have port mc_credit_ret, input, 1 bit: one-cycle pulse that returns one credit.
REQ-015 SHALL have port perr, output, 1 bit: one-cycle pulse when a parity-failed request is dropped.
REQ-016 SHALL have port perr_rid, output, log2x(NPORT) bits: the port that caused perr.
REQ-017 SHALL have port cred_err, output, 1 bit: sticky flag set on credit overflow.
REQ-018 SHALL have port ccnt, output, 4 bits: the current credit count.

Function
REQ-019 SHALL give each port its own FIFO: write on accept, and req_ready = not full, combinational from registered pointers.
REQ-020 SHALL make an entry eligible for arbitration no earlier than the cycle after it is enqueued; minimum req-accept-to-mc_valid latency is 2 cycles.
REQ-021 SHALL, when PARITYEN=1, compare the XOR of the request fields with req.parity at accept; on mismatch the entry is not written, perr=1 and perr_rid=port in the next cycle, and req_ready is unaffected.
REQ-022 SHALL, when several ports mismatch in the same cycle, report the lowest port on perr_rid and drop all mismatched entries.
REQ-023 SHALL issue when ccnt>0 and any FIFO is non-empty: it selects one port, dequeues its head, and registers mc_valid/mc_req/mc_rid in the next cycle, issuing at most one request per cycle.
REQ-024 SHALL, with ARBMODE=0, use a round-robin pointer that starts at port 0 after reset, moves to winner+1 mod NPORT after each issue, and is unchanged when nothing issues.
REQ-025 SHALL, with ARBMODE=1, grant the lowest-numbered non-empty port.
REQ-026 SHALL decrement ccnt on issue, increment it on mc_credit_ret, and leave it unchanged when both occur in the same cycle.
REQ-027 SHALL, on mc_credit_ret with ccnt==NCREDIT and no issue, hold ccnt, set cred_err until reset, and not wrap ccnt.
REQ-028 SHALL, with ccnt==0, issue nothing (mc_valid=0) while FIFOs continue to accept until full.
REQ-029 SHALL permit a same-cycle enqueue and dequeue on a non-full FIFO, leaving the count unchanged.
REQ-030 SHALL let FIFO pointers wrap modulo FIFODEPTH, using an extra MSB to distinguish full from empty.
REQ-031 SHALL keep mc_req and mc_rid stable whenever mc_valid=0 (last value or zero; verification does not check them).

Reset
REQ-032 SHALL, on a clock edge with rst=1, set all FIFOs empty, the round-robin pointer to 0, ccnt to NCREDIT, and mc_valid, perr and cred_err to 0; req_ready is then all 1s from the following cycle.
REQ-033 SHALL, on reset mid-operation, discard queued and in-flight requests; credits returned after reset deassertion are counted normally and trigger cred_err on overflow.

Structure
REQ-034 SHALL define mem_req_word_type, the MEMARB_RR/MEMARB_FIXED constants and the rid-width function in libmemif.
REQ-035 SHALL implement the per-port storage as one sub-module, mem_req_fifo (distributed-RAM FIFO, parameter FIFODEPTH), instantiated NPORT times.
REQ-036 SHALL keep the arbiter, credit counter and parity checker in mem_req_arb itself.

Verification
REQ-037 SHALL verify: NPORT=2, ARBMODE=0, both FIFOs loaded with 3 entries each, credits ample -> mc_rid sequence 0,1,0,1,0,1 on consecutive cycles.
REQ-038 SHALL verify: NCREDIT=4, 6 requests on port 0 and no returns -> exactly 4 mc_valid pulses and ccnt=0; one mc_credit_ret -> 1 more issue 1 cycle later.
REQ-039 SHALL verify: FIFODEPTH=4, ccnt=0, 5 valid requests on port 1 -> req_ready[1]=0 after the 4th accept, the 5th held, and no mc_valid.
REQ-040 SHALL verify: a port-0 request with inverted parity -> perr=1 and perr_rid=0 one cycle later, and the entry is never issued.
REQ-041 SHALL verify: mc_credit_ret with ccnt=4 (NCREDIT=4) and no issue -> ccnt stays 4 and cred_err stays 1 until rst.
REQ-042 SHALL verify: rst asserted with 3 queued entries and ccnt=1 -> next cycle mc_valid=0, ccnt=4, and all req_ready=1.
